// File: rtl/pht_upd_ctrl.sv
// PHT update controller: arbitrates one single-port counter array between fetch
// reads, queued 2-bit counter updates and an optional whole-table clear (PHT_CLR_EN).
module pht_upd_ctrl #(
  parameter int         LOG_INDEX    = 10,
  parameter int         SATCNT_WIDTH = 2,
  parameter logic [1:0] SATCNT_INIT  = 2'b10,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    upd_vld_i,
  input  logic [LOG_INDEX-1:0]    upd_index_i,
  input  logic                    upd_dir_i,
  output logic                    upd_rdy_o,
  input  logic                    clr_req_i,
  output logic                    clr_busy_o,
  input  logic                    fe_rd_vld_i,
  input  logic [LOG_INDEX-1:0]    fe_rd_index_i,
  output logic                    fe_stall_o,
  output logic                    fe_pred_vld_o,
  output logic                    fe_pred_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [LOG_INDEX-1:0]    mem_addr_o,
  output logic [SATCNT_WIDTH-1:0] mem_wdata_o,
  input  logic [SATCNT_WIDTH-1:0] mem_rdata_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [LOG_INDEX-1:0] LAST_ADDR = {LOG_INDEX{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, CLR = 2'd3} state_t;

  state_t               state_r;
  logic [LOG_INDEX-1:0] q_index_r [FIFO_DEPTH];
  logic                 q_dir_r   [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [LOG_INDEX-1:0] clr_addr_r;
  logic                 clr_pend_r;
  logic                 fe_pred_vld_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 q_full_s;
  logic                 q_empty_s;
  logic                 fe_acc_s;
  logic                 clr_hit_s;
  logic [LOG_INDEX-1:0] head_index_s;
  logic                 head_dir_s;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

`ifdef PHT_CLR_EN
  localparam state_t RESET_STATE = CLR;
  assign clr_hit_s  = clr_req_i | clr_pend_r;
  assign clr_busy_o = reset_n && (state_r == CLR);
`else
  localparam state_t RESET_STATE = IDLE;
  logic unused_s;
  assign unused_s   = clr_req_i ^ clr_pend_r;
  assign clr_hit_s  = 1'b0;
  assign clr_busy_o = 1'b0;
`endif

  assign q_full_s      = (count_r == FULL_CNT);
  assign q_empty_s     = (count_r == CNT_W'(0));
  assign upd_rdy_o     = !q_full_s;
  assign push_s        = upd_vld_i && !q_full_s;
  assign pop_s         = (state_r == WR);
  assign head_index_s  = q_index_r[rd_ptr_r];
  assign head_dir_s    = q_dir_r[rd_ptr_r];
  // Fetch owns the port in every IDLE cycle; updates and clear only claim it from their own states
  assign fe_acc_s      = reset_n && (state_r == IDLE) && fe_rd_vld_i;
  assign fe_stall_o    = reset_n && fe_rd_vld_i && (state_r != IDLE);
  assign fe_pred_vld_o = fe_pred_vld_r;
  assign fe_pred_o     = fe_pred_vld_r & mem_rdata_i[1];

  // FSM, clear walk address, pending-clear latch and fetch response valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RESET_STATE;
      clr_addr_r    <= '0;
      clr_pend_r    <= 1'b0;
      fe_pred_vld_r <= 1'b0;
    end else begin
      fe_pred_vld_r <= fe_acc_s;
      case (state_r)
        IDLE: begin
          if (clr_hit_s) begin
            state_r    <= CLR;
            clr_pend_r <= 1'b0;
            clr_addr_r <= '0;
          end else if (!q_empty_s && (!fe_rd_vld_i || q_full_s)) begin
            state_r <= RD;
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          state_r    <= WR;
          clr_pend_r <= clr_hit_s;
        end
        WR: begin
          if (clr_hit_s) begin
            state_r    <= CLR;
            clr_pend_r <= 1'b0;
            clr_addr_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        CLR: begin
          clr_addr_r <= clr_addr_r + LOG_INDEX'(1);
          state_r    <= (clr_addr_r == LAST_ADDR) ? IDLE : CLR;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Update queue pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue payload; slots are only consumed while counted as occupied, so no reset
  always_ff @(posedge clock) begin
    if (push_s) begin
      q_index_r[wr_ptr_r] <= upd_index_i;
      q_dir_r[wr_ptr_r]   <= upd_dir_i;
    end
  end

  // Array port mux: the FSM state selects the single owner of this cycle's access
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (reset_n) begin
      case (state_r)
        IDLE: begin
          mem_en_o   = fe_acc_s;
          mem_addr_o = fe_rd_index_i;
        end
        RD: begin
          mem_en_o   = 1'b1;
          mem_addr_o = head_index_s;
        end
        WR: begin
          mem_en_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = head_index_s;
          mem_wdata_o = SATCNT_WIDTH'(sat_update(mem_rdata_i[1:0], head_dir_s));
        end
        CLR: begin
          mem_en_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = clr_addr_r;
          mem_wdata_o = SATCNT_WIDTH'(SATCNT_INIT);
        end
        default: begin
          mem_en_o = 1'b0;
        end
      endcase
    end else begin
      mem_en_o = 1'b0;
      mem_we_o = 1'b0;
    end
  end

endmodule
